// File: rtl/product_accumulator.sv
// Accumulates a frame of COUNT unsigned 8-bit products into a saturating sum and
// presents the result, with a sticky saturation flag, on a valid/ready output.
module product_accumulator #(
  parameter int unsigned ACC_W = 12,
  parameter int unsigned COUNT = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e             r_state, w_state_d;
  logic [ACC_W-1:0]   r_acc, w_acc_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic               r_ovf, w_ovf_d;
  logic [ACC_W-1:0]   r_sum, w_sum_d;
  logic               r_sum_ovf, w_sum_ovf_d;

  logic [ACC_W:0]     w_prod_ext;
  logic [ACC_W:0]     w_sum_ext;
  logic               w_carry;
  logic [ACC_W-1:0]   w_sat;
  logic               w_last;

  // Extra top bit of the sum is the carry that triggers saturation.
  assign w_prod_ext = {{(ACC_W - 7){1'b0}}, in_product};
  assign w_sum_ext  = {1'b0, r_acc} + w_prod_ext;
  assign w_carry    = w_sum_ext[ACC_W];
  assign w_sat      = w_carry ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
  assign w_last     = (r_cnt == CNT_W'(COUNT - 1));

  assign in_ready  = (r_state == StAccum);
  assign out_valid = (r_state == StHold);
  assign out_sum   = r_sum;
  assign out_ovf   = r_sum_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StAccum;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_acc_d     = r_acc;
    w_cnt_d     = r_cnt;
    w_ovf_d     = r_ovf;
    w_sum_d     = r_sum;
    w_sum_ovf_d = r_sum_ovf;
    if (clear) begin
      // Abort: any offered product is dropped and any held result is discarded.
      w_state_d = StAccum;
      w_acc_d   = '0;
      w_cnt_d   = '0;
      w_ovf_d   = 1'b0;
    end else begin
      unique case (r_state)
        StAccum: begin
          if (in_valid) begin
            w_acc_d = w_sat;
            w_cnt_d = r_cnt + CNT_W'(1);
            w_ovf_d = r_ovf | w_carry;
            if (w_last) begin
              w_state_d   = StHold;
              w_sum_d     = w_sat;
              w_sum_ovf_d = r_ovf | w_carry;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            w_state_d = StAccum;
            w_acc_d   = '0;
            w_cnt_d   = '0;
            w_ovf_d   = 1'b0;
          end
        end
        default: begin
          w_state_d = StAccum;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_sum     <= '0;
      r_sum_ovf <= 1'b0;
    end else begin
      r_acc     <= w_acc_d;
      r_cnt     <= w_cnt_d;
      r_ovf     <= w_ovf_d;
      r_sum     <= w_sum_d;
      r_sum_ovf <= w_sum_ovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: two instances (ACC_W=12 and ACC_W=8) share one stimulus stream;
// expected results are queued per instance and popped by a monitor on each handshake.
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_product = 8'd0;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [11:0] a_out_sum;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [7:0]  b_out_sum;

  int checks = 0;
  int failures = 0;

  // Entries are {ovf, sum[15:0]}.
  logic [16:0] q_a[$];
  logic [16:0] q_b[$];
  logic [16:0] mon_e_a, mon_e_b;

  product_accumulator #(.ACC_W(12), .COUNT(4), .CNT_W(4)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (a_in_ready),
    .in_product (in_product),
    .out_valid  (a_out_valid),
    .out_ready  (out_ready),
    .out_sum    (a_out_sum),
    .out_ovf    (a_out_ovf)
  );

  product_accumulator #(.ACC_W(8), .COUNT(4), .CNT_W(4)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (b_in_ready),
    .in_product (in_product),
    .out_valid  (b_out_valid),
    .out_ready  (out_ready),
    .out_sum    (b_out_sum),
    .out_ovf    (b_out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic state_both(input string name, input logic exp_ready, input logic exp_valid);
    check({name, "_a_in_ready"}, 32'(a_in_ready), 32'(exp_ready));
    check({name, "_a_out_valid"}, 32'(a_out_valid), 32'(exp_valid));
    check({name, "_b_in_ready"}, 32'(b_in_ready), 32'(exp_ready));
    check({name, "_b_out_valid"}, 32'(b_out_valid), 32'(exp_valid));
  endtask

  task automatic expect_frame(input logic [15:0] sa, input logic oa,
                              input logic [15:0] sb, input logic ob);
    q_a.push_back({oa, sa});
    q_b.push_back({ob, sb});
  endtask

  // Offer one product and leave in_valid asserted after the accepting edge.
  task automatic send(input logic [7:0] p);
    int n;
    n = 0;
    in_valid   = 1'b1;
    in_product = p;
    while (!a_in_ready && n < 50) begin
      step();
      n++;
    end
    if (!a_in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed %0d, required 1", a_in_ready);
    end
    step();
  endtask

  // Called right after the last accept with out_ready=1: result visible now, gone next cycle.
  task automatic finish_frame(input string name);
    in_valid = 1'b0;
    state_both({name, "_latency"}, 1'b0, 1'b1);
    step();
    state_both({name, "_after_consume"}, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (a_out_valid) begin
        if (q_a.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected_result: got sum %0d, required no result", a_out_sum);
        end else begin
          mon_e_a = q_a.pop_front();
          check("a_sum", 32'(a_out_sum), 32'(mon_e_a[15:0]));
          check("a_ovf", 32'(a_out_ovf), 32'(mon_e_a[16]));
        end
      end
      if (b_out_valid) begin
        if (q_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected_result: got sum %0d, required no result", b_out_sum);
        end else begin
          mon_e_b = q_b.pop_front();
          check("b_sum", 32'(b_out_sum), 32'(mon_e_b[15:0]));
          check("b_ovf", 32'(b_out_ovf), 32'(mon_e_b[16]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    rst = 1'b0;
    state_both("reset", 1'b1, 1'b0);
    check("reset_a_sum", 32'(a_out_sum), 32'd0);
    check("reset_a_ovf", 32'(a_out_ovf), 32'd0);
    check("reset_b_sum", 32'(b_out_sum), 32'd0);

    // Basic frame, held in HOLD under backpressure with a stray product offered.
    out_ready = 1'b0;
    send(8'd3); send(8'd5); send(8'd7); send(8'd9);
    state_both("hold_entry", 1'b0, 1'b1);
    in_valid   = 1'b1;
    in_product = 8'd99;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_a_sum", 32'(a_out_sum), 32'd24);
      check("hold_a_ovf", 32'(a_out_ovf), 32'd0);
      check("hold_a_in_ready", 32'(a_in_ready), 32'd0);
      check("hold_a_out_valid", 32'(a_out_valid), 32'd1);
    end
    in_valid = 1'b0;
    expect_frame(16'd24, 1'b0, 16'd24, 1'b0);
    out_ready = 1'b1;
    step();
    state_both("hold_release", 1'b1, 1'b0);

    // Saturation only in the 8-bit instance; flag must clear for the next frame.
    expect_frame(16'd320, 1'b0, 16'd255, 1'b1);
    send(8'd200); send(8'd100); send(8'd10); send(8'd10);
    finish_frame("sat");
    expect_frame(16'd4, 1'b0, 16'd4, 1'b0);
    send(8'd1); send(8'd1); send(8'd1); send(8'd1);
    finish_frame("after_sat");

    // Gapped input.
    expect_frame(16'd900, 1'b0, 16'd255, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send(8'd225);
      if (i < 3) begin
        in_valid = 1'b0;
        step();
      end
    end
    finish_frame("gapped");

    // Clear drops the product offered alongside it.
    send(8'd10); send(8'd20);
    in_valid   = 1'b1;
    in_product = 8'd50;
    clear      = 1'b1;
    check("clear_in_ready", 32'(a_in_ready), 32'd1);
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    state_both("after_clear", 1'b1, 1'b0);
    expect_frame(16'd10, 1'b0, 16'd10, 1'b0);
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    finish_frame("post_clear");

    // Reset while holding a result: it must never be emitted.
    out_ready = 1'b0;
    send(8'd3); send(8'd5); send(8'd7); send(8'd9);
    in_valid = 1'b0;
    check("prerst_a_sum", 32'(a_out_sum), 32'd24);
    check("prerst_a_out_valid", 32'(a_out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    state_both("rst_in_hold", 1'b1, 1'b0);
    check("rst_in_hold_a_sum", 32'(a_out_sum), 32'd0);
    check("rst_in_hold_b_sum", 32'(b_out_sum), 32'd0);
    check("rst_in_hold_a_ovf", 32'(a_out_ovf), 32'd0);
    out_ready = 1'b1;
    expect_frame(16'd8, 1'b0, 16'd8, 1'b0);
    send(8'd2); send(8'd2); send(8'd2); send(8'd2);
    finish_frame("post_rst");

    step();
    step();
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
